// File: rtl/riscv_pkg.sv
// Shared RV32I constants and data-memory controller types.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    DM_IDLE   = 2'd0,
    DM_ACCESS = 2'd1,
    DM_DONE   = 2'd2
  } dmem_state_e;

  // Unknown width codes and misaligned halfword/word accesses are rejected.
  function automatic logic dmem_illegal(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load extraction: selects byte/half from a word by address and extends it.
// Ports: word (SRAM word), addr_lo (byte offset), funct3 (width/sign),
//        result_c (combinational extended result).
module dmem_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result_c = {{24{byte_v[7]}}, byte_v};
      F3_BU:   result_c = {24'd0, byte_v};
      F3_H:    result_c = {{16{half_v[15]}}, half_v};
      F3_HU:   result_c = {16'd0, half_v};
      F3_W:    result_c = word;
      default: result_c = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory responder: drives a fixed-latency SRAM port and
// stalls the pipeline via MEM_RDY until each load/store completes.
// Ports: CLK/RST_N; IM_* request from MEM stage and load result;
//        MEM_RDY (combinational stall), MEM_ERR (illegal access flag);
//        DM_* SRAM port (registered strobes, steered lanes, read word in).
module dmem_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IM_REQ,
  input  logic              IM_WE,
  input  logic [2:0]        IM_FUNCT3,
  input  logic [ADDR_W-1:0] IM_ADDR,
  input  logic [31:0]       IM_WDATA,
  output logic [31:0]       IM_RDATA,
  output logic              MEM_RDY,
  output logic              MEM_ERR,
  output logic              DM_EN,
  output logic              DM_WE,
  output logic [ADDR_W-3:0] DM_ADDR,
  output logic [3:0]        DM_BE,
  output logic [31:0]       DM_WDATA,
  input  logic [31:0]       DM_RDATA
);

  localparam int unsigned CNT_W = 4;

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        alo_q, alo_d;
  logic              en_d, we_d, err_d;
  logic [ADDR_W-3:0] addr_d;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d, rdata_d;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [31:0]       load_res;

  dmem_load_align u_load_align (
    .word     (DM_RDATA),
    .addr_lo  (alo_q),
    .funct3   (f3_q),
    .result_c (load_res)
  );

  // Stall asserts in the same cycle the request appears.
  assign MEM_RDY = (state_q == DM_DONE) || ((state_q == DM_IDLE) && !IM_REQ);

  // Store lane steering; loads enable the whole word.
  always_comb begin
    st_be    = 4'hF;
    st_wdata = IM_WDATA;
    if (IM_WE) begin
      case (IM_FUNCT3)
        F3_B, F3_BU: begin
          st_be    = 4'b0001 << IM_ADDR[1:0];
          st_wdata = {4{IM_WDATA[7:0]}};
        end
        F3_H, F3_HU: begin
          st_be    = 4'b0011 << IM_ADDR[1:0];
          st_wdata = {2{IM_WDATA[15:0]}};
        end
        default: begin
          st_be    = 4'hF;
          st_wdata = IM_WDATA;
        end
      endcase
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    alo_d   = alo_q;
    en_d    = DM_EN;
    we_d    = DM_WE;
    addr_d  = DM_ADDR;
    be_d    = DM_BE;
    wdata_d = DM_WDATA;
    rdata_d = IM_RDATA;
    err_d   = MEM_ERR;
    case (state_q)
      DM_IDLE: begin
        if (IM_REQ) begin
          if (dmem_illegal(IM_FUNCT3, IM_ADDR[1:0])) begin
            state_d = DM_DONE;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = DM_ACCESS;
            addr_d  = IM_ADDR[ADDR_W-1:2];
            be_d    = st_be;
            wdata_d = st_wdata;
            we_d    = IM_WE;
            en_d    = 1'b1;
            f3_d    = IM_FUNCT3;
            alo_d   = IM_ADDR[1:0];
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      DM_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Last access cycle: the SRAM word is valid only now.
          if (!DM_WE) rdata_d = load_res;
          en_d    = 1'b0;
          we_d    = 1'b0;
          state_d = DM_DONE;
        end
      end
      DM_DONE: begin
        state_d = DM_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = DM_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= DM_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      alo_q    <= '0;
      DM_EN    <= 1'b0;
      DM_WE    <= 1'b0;
      DM_ADDR  <= '0;
      DM_BE    <= '0;
      DM_WDATA <= '0;
      IM_RDATA <= '0;
      MEM_ERR  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      alo_q    <= alo_d;
      DM_EN    <= en_d;
      DM_WE    <= we_d;
      DM_ADDR  <= addr_d;
      DM_BE    <= be_d;
      DM_WDATA <= wdata_d;
      IM_RDATA <= rdata_d;
      MEM_ERR  <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: instance A uses WAIT_CYCLES=2, instance B
// WAIT_CYCLES=0; both share inputs except their request lines.
module tb_dmem_ctrl;

  localparam logic [31:0] GARBAGE = 32'h55AA55AA;

  logic        CLK, RST_N, REQ_A, REQ_B, IM_WE;
  logic [2:0]  IM_FUNCT3;
  logic [31:0] IM_ADDR, IM_WDATA, DM_RDATA;

  logic [31:0] a_rdata, b_rdata, a_dm_wdata, b_dm_wdata;
  logic        a_rdy, b_rdy, a_err, b_err, a_en, b_en, a_we, b_we;
  logic [29:0] a_addr, b_addr;
  logic [3:0]  a_be, b_be;

  int checks, errors;
  int lat, en_cnt, we_cnt;
  logic [29:0] o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wdata, o_rdata;
  logic        o_err;

  dmem_ctrl #(.WAIT_CYCLES(2), .ADDR_W(32)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .IM_REQ(REQ_A), .IM_WE(IM_WE), .IM_FUNCT3(IM_FUNCT3),
    .IM_ADDR(IM_ADDR), .IM_WDATA(IM_WDATA), .IM_RDATA(a_rdata), .MEM_RDY(a_rdy),
    .MEM_ERR(a_err), .DM_EN(a_en), .DM_WE(a_we), .DM_ADDR(a_addr), .DM_BE(a_be),
    .DM_WDATA(a_dm_wdata), .DM_RDATA(DM_RDATA)
  );

  dmem_ctrl #(.WAIT_CYCLES(0), .ADDR_W(32)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .IM_REQ(REQ_B), .IM_WE(IM_WE), .IM_FUNCT3(IM_FUNCT3),
    .IM_ADDR(IM_ADDR), .IM_WDATA(IM_WDATA), .IM_RDATA(b_rdata), .MEM_RDY(b_rdy),
    .MEM_ERR(b_err), .DM_EN(b_en), .DM_WE(b_we), .DM_ADDR(b_addr), .DM_BE(b_be),
    .DM_WDATA(b_dm_wdata), .DM_RDATA(DM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issues one request and observes it until MEM_RDY; results land in o_*/lat/en_cnt.
  task automatic run_access(input bit sel, input bit we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rword, input bit keep_req);
    int waits;
    logic rdy, en, wr;
    waits = sel ? 0 : 2;
    IM_WE = we; IM_FUNCT3 = f3; IM_ADDR = addr; IM_WDATA = wdata;
    DM_RDATA = GARBAGE;
    if (sel) REQ_B = 1'b1; else REQ_A = 1'b1;
    lat = 0; en_cnt = 0; we_cnt = 0;
    o_addr = '0; o_be = '0; o_wdata = '0;
    #1;
    rdy = sel ? b_rdy : a_rdy;
    while (rdy !== 1'b1 && lat < 40) begin
      en = sel ? b_en : a_en;
      wr = sel ? b_we : a_we;
      if (en === 1'b1) begin
        en_cnt++;
        if (wr === 1'b1) we_cnt++;
        if (en_cnt == 1) begin
          o_addr  = sel ? b_addr : a_addr;
          o_be    = sel ? b_be : a_be;
          o_wdata = sel ? b_dm_wdata : a_dm_wdata;
        end
        DM_RDATA = (en_cnt == waits + 1) ? rword : GARBAGE;
      end else begin
        DM_RDATA = GARBAGE;
      end
      tick();
      lat++;
      rdy = sel ? b_rdy : a_rdy;
    end
    if ((sel ? b_en : a_en) === 1'b1) en_cnt++;
    o_err   = sel ? b_err : a_err;
    o_rdata = sel ? b_rdata : a_rdata;
    DM_RDATA = GARBAGE;
    if (!keep_req) begin
      REQ_A = 1'b0; REQ_B = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0; IM_WE = 1'b0;
    IM_FUNCT3 = 3'd0; IM_ADDR = '0; IM_WDATA = '0; DM_RDATA = GARBAGE;
    tick(); tick();
    checks++; if ({a_en, a_we, a_err, a_rdy} !== 4'b0001) begin errors++;
      $display("FAIL reset_flags got en/we/err/rdy=%b exp 0001", {a_en, a_we, a_err, a_rdy}); end
    checks++; if (a_addr !== 30'd0 || a_be !== 4'd0) begin errors++;
      $display("FAIL reset_addr_be got %h/%h exp 0/0", a_addr, a_be); end
    checks++; if (a_dm_wdata !== 32'd0 || a_rdata !== 32'd0) begin errors++;
      $display("FAIL reset_data got %h/%h exp 0/0", a_dm_wdata, a_rdata); end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int strobes;
    IM_WE = 1'b1; IM_FUNCT3 = 3'd2; IM_ADDR = 32'h300; IM_WDATA = 32'h11223344;
    REQ_A = 1'b1;
    tick();
    checks++; if (a_en !== 1'b1 || a_we !== 1'b1) begin errors++;
      $display("FAIL rst_mid_active got en/we=%b%b exp 11", a_en, a_we); end
    RST_N = 1'b0; REQ_A = 1'b0;
    tick();
    checks++; if (a_en !== 1'b0 || a_we !== 1'b0 || a_rdy !== 1'b1) begin errors++;
      $display("FAIL rst_mid_idle got en/we/rdy=%b%b%b exp 001", a_en, a_we, a_rdy); end
    RST_N = 1'b1;
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_en === 1'b1 || a_we === 1'b1) strobes++;
      tick();
    end
    checks++; if (strobes != 0) begin errors++;
      $display("FAIL rst_mid_no_strobe got %0d exp 0", strobes); end
  endtask

  task automatic test_lw();
    run_access(1'b0, 1'b0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 1'b0);
    checks++; if (lat != 4) begin errors++;
      $display("FAIL lw_latency got %0d exp 4", lat); end
    checks++; if (en_cnt != 3) begin errors++;
      $display("FAIL lw_en_cycles got %0d exp 3", en_cnt); end
    checks++; if (o_addr !== 30'h40 || o_be !== 4'hF) begin errors++;
      $display("FAIL lw_addr_be got %h/%h exp 40/f", o_addr, o_be); end
    checks++; if (o_rdata !== 32'hDEADBEEF || o_err !== 1'b0) begin errors++;
      $display("FAIL lw_rdata got %h err %b exp deadbeef err 0", o_rdata, o_err); end
  endtask

  task automatic test_load_extend();
    run_access(1'b0, 1'b0, 3'd0, 32'h103, 32'd0, 32'h80123456, 1'b0);
    checks++; if (o_rdata !== 32'hFFFFFF80) begin errors++;
      $display("FAIL lb got %h exp ffffff80", o_rdata); end
    run_access(1'b0, 1'b0, 3'd4, 32'h103, 32'd0, 32'h80123456, 1'b0);
    checks++; if (o_rdata !== 32'h00000080) begin errors++;
      $display("FAIL lbu got %h exp 00000080", o_rdata); end
    run_access(1'b0, 1'b0, 3'd1, 32'h102, 32'd0, 32'h80123456, 1'b0);
    checks++; if (o_rdata !== 32'hFFFF8012) begin errors++;
      $display("FAIL lh got %h exp ffff8012", o_rdata); end
    run_access(1'b0, 1'b0, 3'd5, 32'h100, 32'd0, 32'h80129876, 1'b0);
    checks++; if (o_rdata !== 32'h00009876) begin errors++;
      $display("FAIL lhu got %h exp 00009876", o_rdata); end
  endtask

  task automatic test_store_lanes();
    run_access(1'b0, 1'b1, 3'd0, 32'h201, 32'h000000AB, 32'd0, 1'b0);
    checks++; if (we_cnt != 3 || o_be !== 4'b0010 || o_wdata !== 32'hABABABAB) begin errors++;
      $display("FAIL sb got we %0d be %b wd %h exp 3 0010 abababab", we_cnt, o_be, o_wdata); end
    run_access(1'b0, 1'b1, 3'd1, 32'h202, 32'h00001234, 32'd0, 1'b0);
    checks++; if (o_be !== 4'b1100 || o_wdata !== 32'h12341234 || o_addr !== 30'h80) begin errors++;
      $display("FAIL sh got be %b wd %h a %h exp 1100 12341234 80", o_be, o_wdata, o_addr); end
    // Stores leave the previous load result (LHU 0x9876) untouched.
    checks++; if (o_rdata !== 32'h00009876) begin errors++;
      $display("FAIL store_keeps_rdata got %h exp 00009876", o_rdata); end
  endtask

  task automatic test_illegal();
    run_access(1'b0, 1'b0, 3'd2, 32'h102, 32'd0, 32'h12345678, 1'b0);
    checks++; if (lat != 1 || en_cnt != 0) begin errors++;
      $display("FAIL lw_misalign_timing got lat %0d en %0d exp 1 0", lat, en_cnt); end
    checks++; if (o_err !== 1'b1 || o_rdata !== 32'd0) begin errors++;
      $display("FAIL lw_misalign_resp got err %b rd %h exp 1 0", o_err, o_rdata); end
    checks++; if (a_err !== 1'b0) begin errors++;
      $display("FAIL err_clears got %b exp 0", a_err); end
    run_access(1'b0, 1'b0, 3'd3, 32'h100, 32'd0, 32'h12345678, 1'b0);
    checks++; if (lat != 1 || en_cnt != 0 || o_err !== 1'b1 || o_rdata !== 32'd0) begin errors++;
      $display("FAIL f3_3 got lat %0d en %0d err %b rd %h exp 1 0 1 0", lat, en_cnt, o_err, o_rdata); end
    run_access(1'b0, 1'b1, 3'd1, 32'h201, 32'h0000FFFF, 32'd0, 1'b0);
    checks++; if (en_cnt != 0 || we_cnt != 0 || o_err !== 1'b1) begin errors++;
      $display("FAIL sh_misalign got en %0d we %0d err %b exp 0 0 1", en_cnt, we_cnt, o_err); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b0, 3'd2, 32'h100, 32'd0, 32'h01020304, 1'b1);
    checks++; if (lat != 4 || o_rdata !== 32'h01020304) begin errors++;
      $display("FAIL b2b_lw got lat %0d rd %h exp 4 01020304", lat, o_rdata); end
    // Next instruction's store shows up during DONE; DONE must ignore it.
    IM_WE = 1'b1; IM_ADDR = 32'h104; IM_WDATA = 32'hA5A5A5A5;
    tick();
    checks++; if (a_rdy !== 1'b0 || a_en !== 1'b0) begin errors++;
      $display("FAIL b2b_idle got rdy %b en %b exp 0 0", a_rdy, a_en); end
    run_access(1'b0, 1'b1, 3'd2, 32'h104, 32'hA5A5A5A5, 32'd0, 1'b0);
    checks++; if (lat != 4 || we_cnt != 3 || o_addr !== 30'h41 || o_wdata !== 32'hA5A5A5A5) begin errors++;
      $display("FAIL b2b_sw got lat %0d we %0d a %h wd %h exp 4 3 41 a5a5a5a5", lat, we_cnt, o_addr, o_wdata); end
  endtask

  task automatic test_wait0();
    run_access(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, 32'hCAFEF00D, 1'b0);
    checks++; if (lat != 2 || en_cnt != 1) begin errors++;
      $display("FAIL w0_timing got lat %0d en %0d exp 2 1", lat, en_cnt); end
    checks++; if (o_rdata !== 32'hCAFEF00D) begin errors++;
      $display("FAIL w0_rdata got %h exp cafef00d", o_rdata); end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_reset_mid_access();
    test_lw();
    test_load_extend();
    test_store_lanes();
    test_illegal();
    test_back_to_back();
    test_wait0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory responder for the MEM stage; it is the producer of MEM_RDY, which the hazard unit consumes to stall the pipeline.
- Accepts one load or store per MEM-stage instruction and drives a fixed-latency word-wide data SRAM port.
- Performs byte-lane steering for stores and extraction plus sign/zero extension for loads.
- Holds MEM_RDY low until the access completes.

Parameters:
WAIT_CYCLES, 2, extra SRAM cycles per access (0..15)
ADDR_W, 32, byte address width

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  synchronous active-low reset
IM_REQ  in  1  MEM stage holds a valid load/store
IM_WE  in  1  1=store, 0=load
IM_FUNCT3  in  3  RV32I width/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
IM_ADDR  in  ADDR_W  byte address
IM_WDATA  in  32  store data (rs2), LSB-aligned
IM_RDATA  out  32  extended load result, valid when MEM_RDY=1 in DONE
MEM_RDY  out  1  0 = stall the pipeline
MEM_ERR  out  1  misaligned/illegal access, valid with MEM_RDY in DONE
DM_EN  out  1  SRAM access enable
DM_WE  out  1  SRAM write
DM_ADDR  out  ADDR_W-2  word address
DM_BE  out  4  byte enables
DM_WDATA  out  32  lane-steered write data
DM_RDATA  in  32  SRAM read word, valid in last ACCESS cycle

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Wait counter is 4 bits.
- Reset (RST_N=0 at an edge) → IDLE, counter=0, DM_EN=DM_WE=0, DM_BE=0, DM_ADDR=0, DM_WDATA=0, IM_RDATA=0, MEM_ERR=0.
  - Reset mid-access abandons the access.
  - No DM strobe is issued after the reset edge.
- MEM_RDY is combinational: 1 in IDLE with IM_REQ=0; 0 in IDLE with IM_REQ=1; 0 in ACCESS; 1 in DONE.
  - The stall therefore asserts in the same cycle the request appears.
- IDLE, IM_REQ=1, legal (cycle t):
  - Register DM_ADDR=IM_ADDR[ADDR_W-1:2], DM_BE, DM_WDATA, DM_WE=IM_WE, DM_EN=1.
  - Latch FUNCT3 and ADDR[1:0]; counter=WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - DM_* is held stable.
  - If counter≠0, decrement it.
  - If counter=0, this is the last cycle: latch the extended DM_RDATA into IM_RDATA (loads only; stores leave IM_RDATA unchanged), drop DM_EN/DM_WE, go to DONE.
  - ACCESS lasts WAIT_CYCLES+1 cycles; MEM_RDY=1 at cycle t+WAIT_CYCLES+2.
- DONE:
  - Lasts exactly one cycle, with MEM_RDY=1 (the pipeline advances), then IDLE.
  - IM_REQ in DONE is ignored: it still belongs to the completing instruction.
- IDLE, IM_REQ=1, illegal:
  - Illegal means FUNCT3 ∈ {3,6,7}, H/HU/SH with ADDR[0]=1, or W/SW with ADDR[1:0]≠0.
  - No DM_EN is issued; go directly to DONE with MEM_ERR=1 and IM_RDATA=0.
  - Stores do not write.
- MEM_ERR is 0 in all states except a DONE entered on an error.
- Store lanes:
  - SB: BE=0001<<a[1:0], WDATA={4{wdata[7:0]}}.
  - SH: BE=0011<<a[1:0], WDATA={2{wdata[15:0]}}.
  - SW: BE=1111, WDATA=wdata.
- Loads: DM_BE=1111; select byte/half by a[1:0]; sign-extend for B/H, zero-extend for BU/HU.
- Any DM_RDATA sampled outside the last ACCESS cycle is ignored.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants OP_LOAD=7'b0000011 and OP_STORE=7'b0100011 (shared with the hazard unit);
  - funct3 constants F3_B/H/W/BU/HU;
  - the dmem state enum.
- Sub-module dmem_load_align: combinational (word, a[1:0], funct3) → extended 32-bit result.
- Store lane steering stays inline in dmem_ctrl.

Test Plan:
1. Reset during ACCESS (RST_N=0 at cycle t+1) → next cycle IDLE, DM_EN=0, MEM_RDY=1 with IM_REQ=0; no further DM_WE pulse.
2. WAIT_CYCLES=2, LW addr 0x100, DM_RDATA=0xDEADBEEF → MEM_RDY=0 at cycles t..t+3, 1 at t+4, IM_RDATA=0xDEADBEEF, DM_ADDR=0x40, DM_EN high for exactly 3 cycles.
3. LB addr 0x103, word 0x80123456 → IM_RDATA=0xFFFFFF80; LBU same address → 0x00000080; LH addr 0x102 → 0xFFFF8012.
4. SB addr 0x201, wdata 0x000000AB → DM_WE=1, DM_BE=0010, DM_WDATA=0xABABABAB; SH addr 0x202, wdata 0x1234 → BE=1100, WDATA=0x12341234.
5. LW addr 0x102 → no DM_EN; MEM_RDY=1 at t+1 with MEM_ERR=1, IM_RDATA=0; FUNCT3=3 gives the same response.
6. Back-to-back: LW completes, a new SW is present in the following cycle → accepted in IDLE, with exactly one DONE cycle between the two accesses; WAIT_CYCLES=0 gives MEM_RDY at t+2.
